stream_fork: RTL and testbench

STREAM_FORK -- requirements
Module: stream_fork

---
 rtl/stream_fork_pkg.sv | 19 +
 rtl/fork_fifo.sv | 52 +++++
 rtl/stream_fork.sv | 95 +++++++++
 tb/tb_stream_fork.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_fork_pkg.sv
// Shared definitions for the stream_fork slice: payload width default,
// statistics counter width/type and a saturating increment helper.
// The statistics counters only exist when STREAM_FORK_STAT_EN is defined.
package stream_fork_pkg;

    localparam int DW_DEFAULT = 11;
    localparam int STAT_W     = 16;

    typedef logic [STAT_W-1:0] stat_t;

    // Increment a statistics counter, sticking at all-ones instead of wrapping
    function automatic stat_t sat_inc(input stat_t value, input logic en);
        if (en && (value != '1)) begin
            return value + stat_t'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/fork_fifo.sv
// One branch buffer of stream_fork: DEPTH-entry FIFO with extended pointers.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without an occupancy counter. A full FIFO refuses a push even when it pops
// in the same cycle, which keeps full off any combinational pop path.
module fork_fifo
    import stream_fork_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty   = (r_wr == r_rd);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dat     = r_mem[r_rd[AW-1:0]];

    // Advance write/read pointers; reset empties the buffer at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PTR_ONE;
            if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
        end
    end

    // Payload storage is left unreset; only the pointers decide validity
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/stream_fork.sv
// stream_fork: duplicates one valid/ready stream onto two branches, each
// buffered by its own fork_fifo so the branches drain independently.
// Upstream ready comes only from registered state (FIFO pointers and a
// run flag), never from rdy1/rdy2.
// Optional feature macro: STREAM_FORK_STAT_EN adds saturating transfer
// counters cnt1/cnt2 and a stall-cycle counter.
module stream_fork
    import stream_fork_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          dval1,
    input  logic          rdy1,
    output logic [DW-1:0] d1,
    output logic          dval2,
    input  logic          rdy2,
    output logic [DW-1:0] d2
`ifdef STREAM_FORK_STAT_EN
    ,
    output stat_t         cnt1,
    output stat_t         cnt2,
    output stat_t         stall
`endif
);

    logic r_run;
    logic w_push;
    logic w_full1;
    logic w_full2;
    logic w_empty1;
    logic w_empty2;

    // Ready stays low through reset and rises on the first edge afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_run <= 1'b0;
        else      r_run <= 1'b1;
    end

    assign i_rdy  = r_run && !w_full1 && !w_full2;
    assign w_push = i_dval && i_rdy;
    assign dval1  = !w_empty1;
    assign dval2  = !w_empty2;

    fork_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (i_dat),
        .i_pop   (rdy1),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_dat   (d1)
    );

    fork_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (i_dat),
        .i_pop   (rdy2),
        .o_full  (w_full2),
        .o_empty (w_empty2),
        .o_dat   (d2)
    );

`ifdef STREAM_FORK_STAT_EN
    stat_t r_cnt1;
    stat_t r_cnt2;
    stat_t r_stall;

    // Count branch transfers and upstream stall cycles, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_stall <= '0;
        end else begin
            r_cnt1  <= sat_inc(r_cnt1, dval1 && rdy1);
            r_cnt2  <= sat_inc(r_cnt2, dval2 && rdy2);
            r_stall <= sat_inc(r_stall, i_dval && !i_rdy);
        end
    end

    assign cnt1  = r_cnt1;
    assign cnt2  = r_cnt2;
    assign stall = r_stall;
`endif

endmodule

// File: tb/tb_stream_fork.sv
// Self-checking bench for stream_fork (DW=11, DEPTH=2).
// The reference model is two queues of words plus a run flag: upstream is
// ready when running and both queues hold fewer than DEPTH words; each branch
// shows its queue head. Inputs change on the falling edge, outputs are
// compared 1 ns later, and the model advances on the rising edge.
module tb_stream_fork;
    import stream_fork_pkg::*;

    localparam int DW    = 11;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_dval = 1'b0;
    logic          i_rdy;
    logic [DW-1:0] i_dat = '0;
    logic          dval1;
    logic          rdy1 = 1'b0;
    logic [DW-1:0] d1;
    logic          dval2;
    logic          rdy2 = 1'b0;
    logic [DW-1:0] d2;
`ifdef STREAM_FORK_STAT_EN
    stat_t         cnt1;
    stat_t         cnt2;
    stat_t         stall;
    int            mCnt1  = 0;
    int            mCnt2  = 0;
    int            mStall = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    bit            mRun = 1'b0;

    stream_fork #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_dval (i_dval),
        .i_rdy  (i_rdy),
        .i_dat  (i_dat),
        .dval1  (dval1),
        .rdy1   (rdy1),
        .d1     (d1),
        .dval2  (dval2),
        .rdy2   (rdy2),
        .d2     (d2)
`ifdef STREAM_FORK_STAT_EN
        ,
        .cnt1   (cnt1),
        .cnt2   (cnt2),
        .stall  (stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelRdy();
        return mRun && (q1.size() < DEPTH) && (q2.size() < DEPTH);
    endfunction

    task automatic clearModel();
        q1.delete();
        q2.delete();
        mRun = 1'b0;
`ifdef STREAM_FORK_STAT_EN
        mCnt1  = 0;
        mCnt2  = 0;
        mStall = 0;
`endif
    endtask

    task automatic checkOutput();
        check("i_rdy", 32'(i_rdy), 32'(modelRdy()));
        check("dval1", 32'(dval1), 32'(q1.size() != 0));
        if (q1.size() != 0) check("d1", 32'(d1), 32'(q1[0]));
        check("dval2", 32'(dval2), 32'(q2.size() != 0));
        if (q2.size() != 0) check("d2", 32'(d2), 32'(q2[0]));
`ifdef STREAM_FORK_STAT_EN
        check("cnt1", 32'(cnt1), 32'(mCnt1));
        check("cnt2", 32'(cnt2), 32'(mCnt2));
        check("stall", 32'(stall), 32'(mStall));
`endif
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the model
    task automatic applyStimulus(input bit v, input logic [DW-1:0] dat, input bit r1, input bit r2);
        bit push;
        bit pop1;
        bit pop2;
        bit stalled;
        i_dval = v;
        i_dat  = dat;
        rdy1   = r1;
        rdy2   = r2;
        #1;
        checkOutput();
        push    = v && modelRdy();
        stalled = v && !modelRdy();
        pop1    = r1 && (q1.size() != 0);
        pop2    = r2 && (q2.size() != 0);
        @(posedge clk);
        if (pop1) void'(q1.pop_front());
        if (pop2) void'(q2.pop_front());
        if (push) begin
            q1.push_back(dat);
            q2.push_back(dat);
        end
        mRun = 1'b1;
`ifdef STREAM_FORK_STAT_EN
        if (pop1 && mCnt1 < 65535)     mCnt1++;
        if (pop2 && mCnt2 < 65535)     mCnt2++;
        if (stalled && mStall < 65535) mStall++;
`else
        if (stalled) begin end
`endif
        @(negedge clk);
    endtask

    initial begin
        // Reset held for the first 10 ns: everything idle
        #2;
        check("reset_i_rdy", 32'(i_rdy), 32'd0);
        check("reset_dval1", 32'(dval1), 32'd0);
        check("reset_dval2", 32'(dval2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clearModel();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Free flow: both branches always ready
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Skewed branch: branch 2 stalls, third word held until it pops
        applyStimulus(1'b1, 11'h7FF, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h001, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h002, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h002, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h002, 1'b1, 1'b1);
        applyStimulus(1'b1, 11'h002, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Both full while both pop: no push that cycle, ready again next cycle
        applyStimulus(1'b1, 11'h0A5, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h15A, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h333, 1'b1, 1'b1);
        applyStimulus(1'b1, 11'h333, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with independent branch back-pressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        // Mid-stream reset with one word buffered: it must vanish at once
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 11'h4C3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_dval1", 32'(dval1), 32'd0);
        check("midrst_dval2", 32'(dval2), 32'd0);
        check("midrst_i_rdy", 32'(i_rdy), 32'd0);
        clearModel();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Statistics scenario: 5 branch-1 transfers, 3 branch-2, 4 stalls
        applyStimulus(1'b1, 11'h011, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h022, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h033, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h033, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h033, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h033, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 11'h033, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 11'h044, 1'b1, 1'b0);
        applyStimulus(1'b1, 11'h055, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #1;
`ifdef STREAM_FORK_STAT_EN
        check("stat_cnt1", 32'(cnt1), 32'd5);
        check("stat_cnt2", 32'(cnt2), 32'd3);
        check("stat_stall", 32'(stall), 32'd4);
`endif
        check("stat_end_dval2", 32'(dval2), 32'd1);
        check("stat_end_d2", 32'(d2), 32'h044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
